// File: rtl/addsub_seq.sv
// Multi-cycle add/subtract unit: CHUNK bits per clock through a carry-chained slice adder,
// valid/ready on both sides, WIDTH+1-bit exact result plus ovf/zero/neg flags.
module addsub_seq #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             op_sub,
   input  logic             op_signed,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   result,
   output logic             ovf,
   output logic             zero,
   output logic             neg
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW     = $clog2(NCHUNK + 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             ext_a_q, ext_a_d, ext_b_q, ext_b_d;
   logic             sgn_q, sgn_d, add_u_q, add_u_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH:0]   result_q, result_d;
   logic             ovf_q, ovf_d, zero_q, zero_d, neg_q, neg_d;
   logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;

   logic [CHUNK:0]   slice;
   logic [WIDTH-1:0] sum_shift;
   logic             msb;

   // Slice sum enters at the top of the sum register, so after NCHUNK steps it sits aligned.
   assign slice = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};

   generate
      if (CHUNK == WIDTH) begin : g_one_slice
         assign sum_shift = slice[CHUNK-1:0];
      end else begin : g_multi_slice
         assign sum_shift = {slice[CHUNK-1:0], sum_q[WIDTH-1:CHUNK]};
      end
   endgenerate

   // Bit WIDTH of the (WIDTH+1)-bit sum of the extended operands.
   assign msb = ext_a_q ^ ext_b_q ^ carry_q;

   always_comb begin
      // NOTE: every _d gets its hold value first, so no path can leave it unassigned (no latches).
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      sum_d       = sum_q;
      carry_d     = carry_q;
      ext_a_d     = ext_a_q;
      ext_b_d     = ext_b_q;
      sgn_d       = sgn_q;
      add_u_d     = add_u_q;
      cnt_d       = cnt_q;
      result_d    = result_q;
      ovf_d       = ovf_q;
      zero_d      = zero_q;
      neg_d       = neg_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;

      case (state_q)
         IDLE: begin
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            if (in_valid && in_ready_q) begin
               a_d        = a;
               b_d        = op_sub ? ~b : b;
               carry_d    = op_sub;
               // Extension bits: sign bits when signed, zero (or ~0 for inverted b) when unsigned.
               ext_a_d    = op_signed & a[WIDTH-1];
               ext_b_d    = op_signed ? (b[WIDTH-1] ^ op_sub) : op_sub;
               sgn_d      = op_signed;
               add_u_d    = ~op_sub & ~op_signed;
               sum_d      = '0;
               cnt_d      = '0;
               in_ready_d = 1'b0;
               state_d    = CALC;
            end
         end
         CALC: begin
            in_ready_d = 1'b0;
            if (cnt_q != CW'(NCHUNK)) begin
               a_d     = a_q >> CHUNK;
               b_d     = b_q >> CHUNK;
               carry_d = slice[CHUNK];
               sum_d   = sum_shift;
               cnt_d   = cnt_q + CW'(1);
            end else begin
               result_d    = {msb, sum_q};
               ovf_d       = sgn_q ? (msb ^ sum_q[WIDTH-1]) : msb;
               zero_d      = (sum_q == '0);
               neg_d       = msb & ~add_u_q;
               out_valid_d = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d     = IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         carry_q     <= 1'b0;
         ext_a_q     <= 1'b0;
         ext_b_q     <= 1'b0;
         sgn_q       <= 1'b0;
         add_u_q     <= 1'b0;
         cnt_q       <= '0;
         result_q    <= '0;
         ovf_q       <= 1'b0;
         zero_q      <= 1'b0;
         neg_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sum_q       <= sum_d;
         carry_q     <= carry_d;
         ext_a_q     <= ext_a_d;
         ext_b_q     <= ext_b_d;
         sgn_q       <= sgn_d;
         add_u_q     <= add_u_d;
         cnt_q       <= cnt_d;
         result_q    <= result_d;
         ovf_q       <= ovf_d;
         zero_q      <= zero_d;
         neg_q       <= neg_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign ovf       = ovf_q;
   assign zero      = zero_q;
   assign neg       = neg_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Bench for addsub_seq: four instances (CHUNK=1/2/4/8, WIDTH=8) checked against an
// integer-arithmetic reference model; directed cases run on the CHUNK=2 instance.
module tb_addsub_seq;

   typedef struct {
      logic [8:0] res;
      logic       ovf;
      logic       zero;
      logic       neg;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       in_valid  [4];
   logic       out_ready [4];
   logic       op_sub    [4];
   logic       op_signed [4];
   logic [7:0] a         [4];
   logic [7:0] b         [4];
   logic       in_ready  [4];
   logic       out_valid [4];
   logic [8:0] result    [4];
   logic       ovf       [4];
   logic       zero      [4];
   logic       neg       [4];

   int vectors     = 0;
   int miscompares = 0;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      addsub_seq #(.WIDTH(8), .CHUNK(1 << g)) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .a         (a[g]),
         .b         (b[g]),
         .op_sub    (op_sub[g]),
         .op_signed (op_signed[g]),
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .result    (result[g]),
         .ovf       (ovf[g]),
         .zero      (zero[g]),
         .neg       (neg[g])
      );
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic exp_t model(input logic [7:0] av, input logic [7:0] bv,
                                  input logic s, input logic sg);
      exp_t e;
      int   x, y, r;
      x      = sg ? int'($signed(av)) : int'(av);
      y      = sg ? int'($signed(bv)) : int'(bv);
      r      = s ? x - y : x + y;
      e.res  = 9'(r);
      e.ovf  = sg ? (r < -128 || r > 127) : (r < 0 || r > 255);
      e.zero = (r[7:0] == 8'h00);
      e.neg  = (!s && !sg) ? 1'b0 : e.res[8];
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Presents one operation and returns just after the accepting edge.
   task automatic issue(input int d, input logic [7:0] av, input logic [7:0] bv,
                        input logic s, input logic sg);
      a[d] = av; b[d] = bv; op_sub[d] = s; op_signed[d] = sg;
      in_valid[d] = 1'b1;
      chk("in_ready_before_accept", 32'(in_ready[d]), 32'd1);
      @(posedge clk); #1;
      in_valid[d]  = 1'b0;
      a[d]         = 8'($urandom);
      b[d]         = 8'($urandom);
      op_sub[d]    = ~s;
      op_signed[d] = ~sg;
   endtask

   // Waits (bounded) for out_valid, then checks latency, result and flags.
   task automatic wait_result(input int d, input exp_t e, input string tag);
      int lat = 0;
      for (int i = 1; i <= 30; i++) begin
         @(posedge clk); #1;
         if (out_valid[d] === 1'b1) begin
            lat = i;
            break;
         end
      end
      chk({tag, "_latency"}, 32'(lat), 32'((8 >> d) + 1));
      chk({tag, "_result"}, 32'(result[d]), 32'(e.res));
      chk({tag, "_flags"}, {29'd0, ovf[d], zero[d], neg[d]}, {29'd0, e.ovf, e.zero, e.neg});
      chk({tag, "_in_ready_low"}, 32'(in_ready[d]), 32'd0);
   endtask

   task automatic release_out(input int d, input string tag);
      out_ready[d] = 1'b1;
      @(posedge clk); #1;
      out_ready[d] = 1'b0;
      chk({tag, "_out_valid_drop"}, 32'(out_valid[d]), 32'd0);
      chk({tag, "_in_ready_back"}, 32'(in_ready[d]), 32'd1);
   endtask

   task automatic run_op(input int d, input logic [7:0] av, input logic [7:0] bv,
                         input logic s, input logic sg, input string tag);
      issue(d, av, bv, s, sg);
      wait_result(d, model(av, bv, s, sg), tag);
      release_out(d, tag);
   endtask

   initial begin
      exp_t held;
      rst_n = 1'b0;
      for (int d = 0; d < 4; d++) begin
         in_valid[d] = 1'b0; out_ready[d] = 1'b0; op_sub[d] = 1'b0;
         op_signed[d] = 1'b0; a[d] = 8'h00; b[d] = 8'h00;
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int d = 0; d < 4; d++) begin
         chk("reset_in_ready", 32'(in_ready[d]), 32'd1);
         chk("reset_out_valid", 32'(out_valid[d]), 32'd0);
         chk("reset_result", 32'(result[d]), 32'd0);
         chk("reset_flags", {29'd0, ovf[d], zero[d], neg[d]}, 32'd0);
      end

      // Directed cases on the CHUNK=2 instance.
      run_op(1, 8'h05, 8'h07, 1'b1, 1'b0, "usub_05_07");
      run_op(1, 8'hFF, 8'h01, 1'b0, 1'b0, "uadd_ff_01");
      run_op(1, 8'h12, 8'h34, 1'b0, 1'b0, "uadd_12_34");
      run_op(1, 8'h80, 8'h01, 1'b1, 1'b1, "ssub_80_01");
      run_op(1, 8'h7F, 8'hFF, 1'b0, 1'b1, "sadd_7f_ff");
      run_op(1, 8'h00, 8'h00, 1'b1, 1'b1, "ssub_zero");

      // Backpressure: hold the result while a new operation waits at the input.
      issue(1, 8'h12, 8'h34, 1'b0, 1'b0);
      held = model(8'h12, 8'h34, 1'b0, 1'b0);
      wait_result(1, held, "bp_first");
      a[1] = 8'hAA; b[1] = 8'h55; op_sub[1] = 1'b1; op_signed[1] = 1'b0;
      in_valid[1] = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         chk("bp_out_valid_held", 32'(out_valid[1]), 32'd1);
         chk("bp_in_ready_low", 32'(in_ready[1]), 32'd0);
         chk("bp_result_held", 32'(result[1]), 32'(held.res));
         chk("bp_flags_held", {29'd0, ovf[1], zero[1], neg[1]},
             {29'd0, held.ovf, held.zero, held.neg});
      end
      out_ready[1] = 1'b1;
      @(posedge clk); #1;
      out_ready[1] = 1'b0;
      chk("bp_idle_out_valid", 32'(out_valid[1]), 32'd0);
      chk("bp_idle_in_ready", 32'(in_ready[1]), 32'd1);
      @(posedge clk); #1;
      in_valid[1] = 1'b0;
      chk("bp_new_accepted", 32'(in_ready[1]), 32'd0);
      wait_result(1, model(8'hAA, 8'h55, 1'b1, 1'b0), "bp_new");
      release_out(1, "bp_new");

      // Reset asserted on the second CALC cycle discards the operation.
      issue(1, 8'h33, 8'h44, 1'b0, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("midcalc_in_ready", 32'(in_ready[1]), 32'd1);
      chk("midcalc_out_valid", 32'(out_valid[1]), 32'd0);
      chk("midcalc_result", 32'(result[1]), 32'd0);
      repeat (8) begin
         @(posedge clk); #1;
         chk("midcalc_no_output", 32'(out_valid[1]), 32'd0);
      end
      run_op(1, 8'h9C, 8'h64, 1'b0, 1'b0, "after_reset");

      // Random sweep on every CHUNK setting.
      for (int d = 0; d < 4; d++) begin
         run_op(d, 8'hFF, 8'hFF, 1'b0, 1'b0, "sweep_uadd_max");
         run_op(d, 8'h80, 8'h7F, 1'b1, 1'b1, "sweep_ssub_min");
         for (int i = 0; i < 15; i++) begin
            run_op(d, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), "sweep_rand");
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
